// File: rtl/freq_div_bank.sv
// Bank of run-time programmable clock dividers with per-channel square wave and tick.
// Define FREQ_DIV_BANK_SHADOW_EN to defer period writes to each channel's terminal count.
module freq_div_bank #(
   parameter int CHANNELS       = 2,
   parameter int WIDTH          = 20,
   parameter int CH_W           = 1,
   parameter int DEFAULT_PERIOD = 30000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                wr,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_period,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick
);

   localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

   logic [WIDTH-1:0]    cnt    [CHANNELS];
   logic [WIDTH-1:0]    period [CHANNELS];
   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] term;

   // Out-of-range channel indices match no channel and are dropped.
   always_comb begin
      wr_hit = '0;
      term   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = wr && (wr_ch == CH_W'(i));
         term[i]   = en[i] && (cnt[i] >= period[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++)
            cnt[i] <= '0;
         clk_out <= '0;
         tick    <= '0;
      end else if (sync) begin
         for (int i = 0; i < CHANNELS; i++)
            cnt[i] <= '0;
         clk_out <= '0;
         tick    <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (term[i]) begin
               cnt[i]     <= '0;
               clk_out[i] <= ~clk_out[i];
               tick[i]    <= 1'b1;
            end else if (en[i]) begin
               cnt[i]  <= cnt[i] + WIDTH'(1);
               tick[i] <= 1'b0;
            end else begin
               tick[i] <= 1'b0;
            end
         end
      end
   end

`ifdef FREQ_DIV_BANK_SHADOW_EN
   logic [WIDTH-1:0]    shadow [CHANNELS];
   logic [CHANNELS-1:0] pend;

   // A write arriving on the reload edge itself is the newest value and wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            period[i] <= DEF_P;
            shadow[i] <= '0;
         end
         pend <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync || term[i]) begin
               if (wr_hit[i])
                  period[i] <= wr_period;
               else if (pend[i])
                  period[i] <= shadow[i];
               pend[i] <= 1'b0;
            end else if (wr_hit[i]) begin
               shadow[i] <= wr_period;
               pend[i]   <= 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++)
            period[i] <= DEF_P;
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            if (wr_hit[i])
               period[i] <= wr_period;
      end
   end
`endif

endmodule

// File: tb/tb_freq_div_bank.sv
// Directed bench for freq_div_bank: two channels, DEFAULT_PERIOD overridden to 3.
// Expectations follow FREQ_DIV_BANK_SHADOW_EN where the two builds differ.
module tb_freq_div_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] en = 2'b00;
   logic       sync = 1'b0;
   logic       wr = 1'b0;
   logic [1:0] wr_ch = 2'd0;
   logic [7:0] wr_period = 8'd0;
   logic [1:0] clk_out;
   logic [1:0] tick;

   int n_chk = 0;
   int n_fail = 0;

   logic [1:0] exp_co1 [1:11];
   logic [1:0] exp_tk1 [1:11];
   logic [1:0] exp_co2 [12:19];
   logic [1:0] exp_tk2 [12:19];

   freq_div_bank #(
      .CHANNELS(2),
      .WIDTH(8),
      .CH_W(2),
      .DEFAULT_PERIOD(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .sync(sync),
      .wr(wr),
      .wr_ch(wr_ch),
      .wr_period(wr_period),
      .clk_out(clk_out),
      .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [1:0] co,
                        input logic [1:0] tk);
      n_chk++;
      assert (clk_out === co) else begin
         n_fail++;
         $error("FAIL %s clk_out: got %b expected %b", tag, clk_out, co);
      end
      n_chk++;
      assert (tick === tk) else begin
         n_fail++;
         $error("FAIL %s tick: got %b expected %b", tag, tick, tk);
      end
   endtask

   initial begin
      exp_co1 = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11,
                  2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      exp_tk1 = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00,
                  2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
      exp_co2 = '{2'b11, 2'b01, 2'b11, 2'b01,
                  2'b10, 2'b00, 2'b10, 2'b00};
      exp_tk2 = '{2'b11, 2'b10, 2'b10, 2'b10,
                  2'b11, 2'b10, 2'b10, 2'b10};

      // reset state
      #23;
      check("reset", 2'b00, 2'b00);

      // free run at DEFAULT_PERIOD=3: toggles on edges 4, 8, 12
      rst = 1'b0;
      en  = 2'b11;
      for (int e = 1; e <= 11; e++) begin
         step(1);
         check($sformatf("run_e%0d", e), exp_co1[e], exp_tk1[e]);
      end

      // ch1 -> P=0 written on its terminal edge; ch0 keeps P=3
      wr = 1'b1; wr_ch = 2'd1; wr_period = 8'd0;
      for (int e = 12; e <= 19; e++) begin
         step(1);
         wr = 1'b0;
         check($sformatf("p0_e%0d", e), exp_co2[e], exp_tk2[e]);
      end

      // ch0 P=20 via write under sync, ch1 parked
      sync = 1'b1; en = 2'b01;
      wr = 1'b1; wr_ch = 2'd0; wr_period = 8'd20;
      step(1);
      sync = 1'b0; wr = 1'b0;
      check("sync_p20", 2'b00, 2'b00);
      step(9);
      check("cnt9", 2'b00, 2'b00);
      wr = 1'b1; wr_ch = 2'd0; wr_period = 8'd5;
      step(1);
      wr = 1'b0;
      check("wr5_e1", 2'b00, 2'b00);
`ifdef FREQ_DIV_BANK_SHADOW_EN
      step(1);
      check("shd_hold", 2'b00, 2'b00);
      step(9);
      check("shd_pre20", 2'b00, 2'b00);
      step(1);
      check("shd_t20", 2'b01, 2'b01);
      step(5);
      check("shd_pre6", 2'b01, 2'b00);
      step(1);
      check("shd_t6a", 2'b00, 2'b01);
      step(6);
      check("shd_t6b", 2'b01, 2'b01);
`else
      step(1);
      check("imm_wrap", 2'b01, 2'b01);
      step(5);
      check("imm_pre6", 2'b01, 2'b00);
      step(1);
      check("imm_t6a", 2'b00, 2'b01);
      step(6);
      check("imm_t6b", 2'b01, 2'b01);
`endif

      // ch0 P=5, freeze at count 2 for 10 clocks
      sync = 1'b1; en = 2'b01;
      wr = 1'b1; wr_ch = 2'd0; wr_period = 8'd5;
      step(1);
      sync = 1'b0; wr = 1'b0;
      check("sync_p5", 2'b00, 2'b00);
      step(2);
      en = 2'b00;
      for (int k = 0; k < 10; k++) begin
         step(1);
         check($sformatf("frz%0d", k), 2'b00, 2'b00);
      end
      en = 2'b01;
      step(3);
      check("resume_pre", 2'b00, 2'b00);
      step(1);
      check("resume_tgl", 2'b01, 2'b01);

      // P=3 / P=7, knocked out of phase, then resynced
      sync = 1'b1;
      wr = 1'b1; wr_ch = 2'd0; wr_period = 8'd3;
      step(1);
      wr_ch = 2'd1; wr_period = 8'd7;
      step(1);
      sync = 1'b0; wr = 1'b0; en = 2'b11;
      step(5);
      check("phase_pre", 2'b01, 2'b00);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      check("sync_both", 2'b00, 2'b00);
      step(3);
      check("sync_p3", 2'b00, 2'b00);
      step(1);
      check("sync_t4", 2'b01, 2'b01);
      step(3);
      check("sync_p7", 2'b01, 2'b00);
      step(1);
      check("sync_t8", 2'b10, 2'b11);

      // asynchronous reset between edges
      step(4);
      check("pre_rst", 2'b11, 2'b01);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst", 2'b00, 2'b00);
      #3;
      rst = 1'b0;
      en = 2'b11;
      wr = 1'b1; wr_ch = 2'd3; wr_period = 8'd0;
      step(1);
      wr = 1'b0;
      check("rst_e1", 2'b00, 2'b00);
      step(2);
      check("rst_e3", 2'b00, 2'b00);
      step(1);
      check("rst_e4", 2'b11, 2'b11);
      step(3);
      check("rst_e7", 2'b11, 2'b00);
      step(1);
      check("rst_e8", 2'b00, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
